// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round count, ShiftRows indices and GF(2^8) helpers
package aes_pkg;

    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

    localparam int AES_ROUNDS = 10;

    // Source byte for each ShiftRows output byte; byte i sits at row i%4, column i/4
    localparam int SR_IDX [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: combinational ShiftRows, MixColumns (skipped on the last round), AddRoundKey
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] sbox_out,
    input  logic [127:0] rnd_key,
    input  logic         last_round,
    output logic [127:0] rnd_out
);

    logic [127:0] sr, mc;

    for (genvar i = 0; i < 16; i++) begin : g_sr
        assign sr[127-8*i -: 8] = sbox_out[127-8*SR_IDX[i] -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mc
        assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    assign rnd_out = (last_round ? sr : mc) ^ rnd_key;

endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box lookup with a registered output (one cycle latency)
module aes_sbox (
    input  logic       clk,
    input  logic [7:0] d,
    output logic [7:0] q
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0] q_d, q_q;

    // Table lookup
    always_comb q_d = SBOX[d];

    // Output register; no reset needed, it is always overwritten before use
    always_ff @(posedge clk) q_q <= q_d;

    assign q = q_q;

endmodule

// File: rtl/aes_enc128_core.sv
// aes_enc128_core: iterative AES-128 encryptor, one round per two cycles, valid/ready handshakes.
// Optional sideband tag (in_tag/out_tag) enabled by defining AES_ENC_TAG_EN.
module aes_enc128_core
    import aes_pkg::*;
#(
    parameter int KEY_LAT = 21
`ifdef AES_ENC_TAG_EN
    , parameter int TAG_W = 8
`endif
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                aes_key_vld,
    input  logic [10:0][127:0]  aes_key,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [127:0]        in_data,
`ifdef AES_ENC_TAG_EN
    input  logic [TAG_W-1:0]    in_tag,
    output logic [TAG_W-1:0]    out_tag,
`endif
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [127:0]        out_data
);

    localparam int CW = $clog2(KEY_LAT + 1);

    state_t          state_q, state_d;
    logic [127:0]    st_q, st_d;
    logic [3:0]      round_q, round_d;
    logic            key_ok_q, key_ok_d;
    logic [CW-1:0]   key_cnt_q, key_cnt_d;
    logic [127:0]    sbox_out, rnd_out;
    logic            accept, last_round;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .clk (clk),
            .d   (st_q[127-8*i -: 8]),
            .q   (sbox_out[127-8*i -: 8])
        );
    end

    assign last_round = (round_q == 4'(AES_ROUNDS));

    aes_enc_round u_round (
        .sbox_out   (sbox_out),
        .rnd_key    (aes_key[round_q]),
        .last_round (last_round),
        .rnd_out    (rnd_out)
    );

    assign in_rdy   = (state_q == IDLE) && key_ok_q && (key_cnt_q == '0) && !aes_key_vld;
    assign accept   = in_vld && in_rdy;
    assign out_vld  = (state_q == DONE);
    assign out_data = out_vld ? st_q : '0;

    // Next-state: key tracking, round sequencing, abort on key reload during SUB/MIX
    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        round_d   = round_q;
        key_ok_d  = key_ok_q | aes_key_vld;
        // The pulse cycle itself counts, so the counter reaches zero KEY_LAT cycles after it
        key_cnt_d = aes_key_vld ? CW'(KEY_LAT - 1) : (key_cnt_q != '0) ? key_cnt_q - CW'(1) : key_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    st_d    = in_data ^ aes_key[0];
                    round_d = 4'd1;
                    state_d = SUB;
                end
            end
            SUB:  state_d = aes_key_vld ? IDLE : MIX;
            MIX: begin
                st_d    = rnd_out;
                round_d = last_round ? round_q : round_q + 4'd1;
                state_d = aes_key_vld ? IDLE : last_round ? DONE : SUB;
            end
            DONE: state_d = out_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            st_q      <= '0;
            round_q   <= '0;
            key_ok_q  <= 1'b0;
            key_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            round_q   <= round_d;
            key_ok_q  <= key_ok_d;
            key_cnt_q <= key_cnt_d;
        end
    end

`ifdef AES_ENC_TAG_EN
    logic [TAG_W-1:0] tag_q, tag_d;

    // Capture the sideband tag with the accepted block
    always_comb tag_d = accept ? in_tag : tag_q;

    // Tag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= '0;
        else        tag_q <= tag_d;
    end

    assign out_tag = out_vld ? tag_q : '0;
`endif

endmodule

// File: tb/tb_aes_enc128_core.sv
// tb_aes_enc128_core: scoreboard bench for the AES-128 core using FIPS-197 and GCM known vectors
module tb_aes_enc128_core;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] P2 = 128'h00000000000000000000000000000002;
    localparam logic [127:0] Z2 = 128'h0388dace60b6a392f328c2b971b2fe78;

    localparam logic [7:0] TSBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef struct packed {
        logic [127:0] d;
        logic [7:0]   tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              aes_key_vld = 1'b0;
    logic [10:0][127:0] aes_key = '0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic [127:0]      in_data = '0;
    logic              out_vld;
    logic              out_rdy = 1'b1;
    logic [127:0]      out_data;
`ifdef AES_ENC_TAG_EN
    logic [7:0]        in_tag = '0;
    logic [7:0]        out_tag;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    aes_enc128_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aes_key_vld (aes_key_vld),
        .aes_key     (aes_key),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_data     (in_data),
`ifdef AES_ENC_TAG_EN
        .in_tag      (in_tag),
        .out_tag     (out_tag),
`endif
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0][127:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [10:0][127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {TSBOX[t[23:16]], TSBOX[t[15:8]], TSBOX[t[7:0]], TSBOX[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    task automatic load_key(input logic [127:0] k, output int kc);
        @(negedge clk);
        aes_key     = expand(k);
        aes_key_vld = 1'b1;
        kc          = cyc;
        @(negedge clk);
        aes_key_vld = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic [7:0] tag, input logic [127:0] exp,
                        input bit push, output int acc);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_vld  = 1'b1;
        in_data = d;
`ifdef AES_ENC_TAG_EN
        in_tag  = tag;
`endif
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_rdy) ok = 1'b1;
            else @(negedge clk);
        end
        acc = cyc;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_accept: in_rdy=0, required 1 within 200 cycles");
        end else if (push) begin
            sb_q.push_back({exp, tag});
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_out(output int vc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_vld) ok = 1'b1;
        end
        vc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
        rst_n  = 1'b1;
        in_vld = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({in_rdy, out_vld} !== 2'b00) begin
                failures++;
                $display("FAIL nokey_idle: cycle %0d in_rdy=%b out_vld=%b want 0/0", i, in_rdy, out_vld);
            end
        end
        in_vld = 1'b0;
    endtask

    task automatic test_fips_b();
        int kc, rc, acc, vc;
        bit ok;
        exp_t e;
        load_key(KB, kc);
        rc = -1;
        for (int i = 0; i < 100 && rc < 0; i++) begin
            @(negedge clk);
            if (in_rdy) rc = cyc;
        end
        checks++;
        if (rc - kc != 21) begin failures++; $display("FAIL key_latency: in_rdy after %0d cycles want 21", rc - kc); end
        send(PB, 8'h00, CB, 1'b1, acc);
        wait_out(vc, ok);
        checks += 2;
        if (!ok) begin
            failures++;
            $display("FAIL fips_b_timeout: out_vld=0 want 1");
        end else begin
            if (vc - acc != 21) begin failures++; $display("FAIL enc_latency: got %0d want 21", vc - acc); end
            e = sb_q.pop_front();
            if (out_data !== e.d) begin failures++; $display("FAIL fips_b_data: got %h want %h", out_data, e.d); end
        end
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL fips_b_release: out_vld=%b want 0", out_vld); end
    endtask

    task automatic test_backpressure();
        int kc, acc, vc;
        bit ok;
        exp_t e;
        logic [127:0] held;
        out_rdy = 1'b0;
        load_key(KC, kc);
        send(PC, 8'h00, CC, 1'b1, acc);
        wait_out(vc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_timeout: out_vld=0 want 1");
        end else begin
            e = sb_q.pop_front();
            if (out_data !== e.d) begin failures++; $display("FAIL fips_c_data: got %h want %h", out_data, e.d); end
        end
        held = e.d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || out_data !== held || in_rdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d out_vld=%b in_rdy=%b data=%h want 1/0/%h", i, out_vld, in_rdy, out_data, held);
            end
        end
        out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_vld=%b in_rdy=%b want 0/1", out_vld, in_rdy);
        end
    endtask

    task automatic test_abort();
        int kc, acc, vc, rc;
        bit ok, seen;
        exp_t e;
        load_key(KB, kc);
        send(PB, 8'h00, CB, 1'b0, acc);
        do @(negedge clk); while (cyc < acc + 8);
        aes_key     = expand(KC);
        aes_key_vld = 1'b1;
        kc          = cyc;
        @(negedge clk);
        aes_key_vld = 1'b0;
        seen = 1'b0;
        rc   = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_vld) seen = 1'b1;
            if (in_rdy && rc < 0) rc = cyc;
            @(negedge clk);
        end
        checks += 2;
        if (seen) begin failures++; $display("FAIL abort_no_output: out_vld=1 want 0"); end
        if (rc - kc != 21) begin failures++; $display("FAIL abort_rdy_latency: got %0d want 21", rc - kc); end
        send(PC, 8'h00, CC, 1'b1, acc);
        wait_out(vc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_next_timeout: out_vld=0 want 1");
        end else begin
            e = sb_q.pop_front();
            if (out_data !== e.d) begin failures++; $display("FAIL abort_next_data: got %h want %h", out_data, e.d); end
        end
    endtask

    task automatic test_reset_mid();
        int kc, acc, vc;
        bit ok, bad;
        exp_t e;
        load_key(KB, kc);
        send(PB, 8'h00, CB, 1'b0, acc);
        do @(negedge clk); while (cyc < acc + 13);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL midrst_out_vld: got %b want 0", out_vld); end
        if (out_data !== '0) begin failures++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL midrst_in_rdy: got %b want 0", in_rdy); end
        @(negedge clk);
        rst_n  = 1'b1;
        in_vld = 1'b1;
        bad    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_rdy !== 1'b0 || out_vld !== 1'b0) bad = 1'b1;
        end
        in_vld = 1'b0;
        checks++;
        if (bad) begin failures++; $display("FAIL midrst_keyless: in_rdy/out_vld=1 want 0 until key reload"); end
        load_key(KC, kc);
        send(PC, 8'h00, CC, 1'b1, acc);
        wait_out(vc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrst_recover_timeout: out_vld=0 want 1");
        end else begin
            e = sb_q.pop_front();
            if (out_data !== e.d) begin failures++; $display("FAIL midrst_recover_data: got %h want %h", out_data, e.d); end
        end
    endtask

    task automatic test_back_to_back();
        int kc, acc, vc;
        bit ok;
        exp_t e;
        logic [7:0] tags [2];
        logic [127:0] pts [2];
        logic [127:0] cts [2];
        tags = '{8'ha5, 8'h3c};
        pts  = '{128'h0, P2};
        cts  = '{Z0, Z2};
        load_key(128'h0, kc);
        vc = 0;
        for (int b = 0; b < 2; b++) begin
            send(pts[b], tags[b], cts[b], 1'b1, acc);
            if (b == 1) begin
                checks++;
                if (acc != vc + 1) begin failures++; $display("FAIL b2b_gap: accepted %0d cycles after output want 1", acc - vc); end
            end
            wait_out(vc, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL b2b_timeout: block %0d out_vld=0 want 1", b);
            end else begin
                e = sb_q.pop_front();
                if (out_data !== e.d) begin failures++; $display("FAIL b2b_data: block %0d got %h want %h", b, out_data, e.d); end
`ifdef AES_ENC_TAG_EN
                checks++;
                if (out_tag !== e.tag) begin failures++; $display("FAIL b2b_tag: block %0d got %h want %h", b, out_tag, e.tag); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_empty: %0d left want 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
